// File: rtl/id_fetch_aligner.sv
// -----------------------------------------------------------------------------
// id_fetch_aligner
//
// ID-side consumer of the word-aligned fetch stream. Breaks 32-bit fetch
// words into halfwords, realigns them into 16-bit (RVC) and 32-bit
// instructions, and presents each instruction with its PC. A static predictor
// runs at issue: JAL, C.J and C.JAL are always taken, and conditional branches
// are taken when their offset is negative. A taken prediction or an EX flush
// redirects fetch and discards the wrong-path words still in flight.
//
// Ports
//   clk, resetn     clock; synchronous active-low reset
//   fetch_word_i    fetch word, [15:0] is the lower-address halfword
//   fetch_valid_i   fetch word valid
//   fetch_ready_o   word accepted this cycle when valid & ready
//   stall_i         downstream stall, output registers hold
//   flush_i         EX mispredict flush, highest priority after reset
//   flush_pc_i      restart PC for the flush
//   instr_o         instruction; RVC zero-extended; 32'h13 when invalid
//   instr_pc_o      PC of instr_o
//   instr_valid_o   instr_o valid
//   is_compress_o   instr_o is a 16-bit instruction
//   taken_o         one-cycle redirect pulse to fetch
//   redirect_pc_o   redirect target, meaningful while taken_o is high
// -----------------------------------------------------------------------------
module id_fetch_aligner #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned DROP_WORDS = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] fetch_word_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        is_compress_o,
  output logic        taken_o,
  output logic [31:0] redirect_pc_o
);

  localparam int unsigned    DCW         = (DROP_WORDS < 2) ? 1 : $clog2(DROP_WORDS + 1);
  localparam logic [DCW-1:0] DROP_RELOAD = DCW'(DROP_WORDS);
  // The word accepted on the redirect edge is already one of the wrong-path
  // words, so it counts toward the drop.
  localparam logic [DCW-1:0] DROP_AFTER  = DCW'((DROP_WORDS == 0) ? 0 : DROP_WORDS - 1);
  localparam logic [31:0]    NOP         = 32'h0000_0013;

  // Halfword buffer, entry 0 is the head (lowest address).
  logic [2:0][15:0] hw_q, hw_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      head_pc_q, head_pc_d;
  logic [DCW-1:0]   drop_q, drop_d;
  logic             skip_q, skip_d;

  logic        head_rvc, head_complete, issue, accept, predict, redirect;
  logic [1:0]  consumed, remain;
  logic [31:0] head_instr, imm, target;
  logic [15:0] c_hw;

  assign head_rvc      = (hw_q[0][1:0] != 2'b11);
  assign head_complete = ((cnt_q != 2'd0) && head_rvc) || (cnt_q >= 2'd2);
  assign issue         = ~stall_i & head_complete & ~flush_i;
  assign consumed      = !issue ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);
  assign remain        = cnt_q - consumed;
  // Room for a full word exists once at most one halfword survives this
  // cycle's issue; this is why ready depends combinationally on stall_i.
  assign fetch_ready_o = (remain <= 2'd1) & ~flush_i;
  assign accept        = fetch_valid_i & fetch_ready_o;
  assign head_instr    = head_rvc ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign c_hw          = hw_q[0];

  // Static prediction and target of the head instruction.
  // NOTE: always_comb gives every output a default first, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    predict = 1'b0;
    imm     = '0;
    if (head_rvc) begin
      if (c_hw[1:0] == 2'b01 && (c_hw[15:13] == 3'b101 || c_hw[15:13] == 3'b001)) begin
        // C.J / C.JAL
        predict = 1'b1;
        imm     = {{21{c_hw[12]}}, c_hw[8], c_hw[10:9], c_hw[6], c_hw[7],
                   c_hw[2], c_hw[11], c_hw[5:3], 1'b0};
      end else if (c_hw[1:0] == 2'b01 && c_hw[15:14] == 2'b11) begin
        // C.BEQZ / C.BNEZ, backward when the sign bit is set
        predict = c_hw[12];
        imm     = {{24{c_hw[12]}}, c_hw[6:5], c_hw[2], c_hw[11:10], c_hw[4:3], 1'b0};
      end
    end else begin
      case (head_instr[6:0])
        7'b1101111: begin // JAL
          predict = 1'b1;
          imm     = {{12{head_instr[31]}}, head_instr[19:12], head_instr[20],
                     head_instr[30:21], 1'b0};
        end
        7'b1100011: begin // BRANCH, backward when the sign bit is set
          predict = head_instr[31];
          imm     = {{20{head_instr[31]}}, head_instr[7], head_instr[30:25],
                     head_instr[11:8], 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign target   = head_pc_q + imm;
  assign redirect = issue & predict;

  // Buffer, PC and drop bookkeeping: pop what issues, then append what is
  // accepted, then let a flush or redirect override everything.
  // NOTE: combinational next-state logic uses blocking assignments so later
  // statements see the updates of earlier ones; registers use non-blocking.
  always_comb begin
    hw_d      = hw_q;
    cnt_d     = remain;
    head_pc_d = head_pc_q;
    drop_d    = drop_q;
    skip_d    = skip_q;

    case (consumed)
      2'd1: begin
        hw_d[0] = hw_q[1];
        hw_d[1] = hw_q[2];
      end
      2'd2: hw_d[0] = hw_q[2];
      default: ;
    endcase

    if (issue) head_pc_d = head_pc_q + (head_rvc ? 32'd2 : 32'd4);

    if (accept) begin
      if (drop_q != '0) begin
        drop_d = drop_q - DCW'(1);
      end else if (skip_q) begin
        // Restart PC pointed at the upper halfword of this word.
        hw_d[remain] = fetch_word_i[31:16];
        cnt_d        = remain + 2'd1;
        skip_d       = 1'b0;
      end else begin
        hw_d[remain]        = fetch_word_i[15:0];
        hw_d[remain + 2'd1] = fetch_word_i[31:16];
        cnt_d               = remain + 2'd2;
      end
    end

    if (flush_i) begin
      cnt_d     = 2'd0;
      head_pc_d = flush_pc_i;
      skip_d    = flush_pc_i[1];
      drop_d    = DROP_RELOAD;
    end else if (redirect) begin
      cnt_d     = 2'd0;
      head_pc_d = target;
      skip_d    = target[1];
      drop_d    = accept ? DROP_AFTER : DROP_RELOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= 2'd0;
      head_pc_q <= RESET_PC;
      drop_q    <= '0;
      skip_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      head_pc_q <= head_pc_d;
      drop_q    <= drop_d;
      skip_q    <= skip_d;
    end
  end

  // NOTE: the halfword storage is not reset; cnt_q alone decides which
  // entries are meaningful, so their contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    hw_q <= hw_d;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      instr_o       <= NOP;
      instr_pc_o    <= '0;
      instr_valid_o <= 1'b0;
      is_compress_o <= 1'b0;
      taken_o       <= 1'b0;
      redirect_pc_o <= '0;
    end else if (flush_i) begin
      instr_o       <= NOP;
      instr_valid_o <= 1'b0;
      taken_o       <= 1'b1;
      redirect_pc_o <= flush_pc_i;
    end else if (stall_i) begin
      // Hold everything, but never repeat a redirect pulse.
      taken_o <= 1'b0;
    end else if (issue) begin
      instr_o       <= head_instr;
      instr_pc_o    <= head_pc_q;
      instr_valid_o <= 1'b1;
      is_compress_o <= head_rvc;
      taken_o       <= predict;
      if (predict) redirect_pc_o <= target;
    end else begin
      instr_o       <= NOP;
      instr_valid_o <= 1'b0;
      taken_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_id_fetch_aligner
//
// Self-checking bench for id_fetch_aligner. A reference model built on a
// halfword queue tracks the instruction stream, static prediction, drops and
// flushes. Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_id_fetch_aligner;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam int          DROP_WORDS = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] fetch_word_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        is_compress_o;
  logic        taken_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  id_fetch_aligner #(
    .RESET_PC  (RESET_PC),
    .DROP_WORDS(DROP_WORDS)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .fetch_word_i (fetch_word_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_valid_o(instr_valid_o),
    .is_compress_o(is_compress_o),
    .taken_o      (taken_o),
    .redirect_pc_o(redirect_pc_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [15:0] m_q[$];
  logic [31:0] m_pc;
  int          m_drop;
  bit          m_skip;
  logic [31:0] e_instr, e_pc, e_redir;
  bit          e_valid, e_comp, e_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Static prediction computed with plain arithmetic on the encoded fields.
  function automatic void predict(input logic [31:0] ins, input bit rvc,
                                  output bit taken, output int off);
    logic [15:0] c;
    c     = ins[15:0];
    taken = 1'b0;
    off   = 0;
    if (rvc) begin
      if (c[1:0] == 2'b01 && (c[15:13] == 3'b101 || c[15:13] == 3'b001)) begin
        taken = 1'b1;
        off   = int'(c[5:3]) * 2 + int'(c[11]) * 16 + int'(c[2]) * 32 + int'(c[7]) * 64
              + int'(c[6]) * 128 + int'(c[10:9]) * 256 + int'(c[8]) * 1024 - int'(c[12]) * 2048;
      end else if (c[1:0] == 2'b01 && (c[15:13] == 3'b110 || c[15:13] == 3'b111)) begin
        taken = c[12];
        off   = int'(c[4:3]) * 2 + int'(c[11:10]) * 8 + int'(c[2]) * 32
              + int'(c[6:5]) * 64 - int'(c[12]) * 256;
      end
    end else if (ins[6:0] == 7'b1101111) begin
      taken = 1'b1;
      off   = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
            - int'(ins[31]) * (1 << 20);
    end else if (ins[6:0] == 7'b1100011) begin
      taken = ins[31];
      off   = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
            - int'(ins[31]) * 4096;
    end
  endfunction

  task automatic check_outputs();
    check("valid", {31'b0, instr_valid_o}, {31'b0, e_valid});
    check("taken", {31'b0, taken_o}, {31'b0, e_taken});
    check("instr", instr_o, e_instr);
    if (e_valid) begin
      check("pc", instr_pc_o, e_pc);
      check("compress", {31'b0, is_compress_o}, {31'b0, e_comp});
    end
    if (e_taken) check("redirect", redirect_pc_o, e_redir);
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_word_i  = '0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    flush_pc_i    = '0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    m_q.delete();
    m_pc    = RESET_PC;
    m_drop  = 0;
    m_skip  = 1'b0;
    e_instr = NOP;
    e_pc    = '0;
    e_redir = '0;
    e_valid = 1'b0;
    e_comp  = 1'b0;
    e_taken = 1'b0;
  endtask

  // One clock cycle: drive, check ready, clock, advance model, check outputs.
  task automatic step(input bit v, input logic [31:0] w, input bit st = 1'b0,
                      input bit fl = 1'b0, input logic [31:0] fpc = '0);
    bit          rvc, complete, iss, e_ready, acc, pt;
    int          cons, off;
    logic [31:0] ins, tgt;
    fetch_valid_i = v;
    fetch_word_i  = w;
    stall_i       = st;
    flush_i       = fl;
    flush_pc_i    = fpc;
    rvc      = (m_q.size() >= 1) && (m_q[0][1:0] != 2'b11);
    complete = rvc || (m_q.size() >= 2);
    iss      = !st && complete && !fl;
    cons     = !iss ? 0 : (rvc ? 1 : 2);
    e_ready  = ((m_q.size() - cons) <= 1) && !fl;
    acc      = v && e_ready;
    pt       = 1'b0;
    tgt      = '0;
    #1;
    check("ready", {31'b0, fetch_ready_o}, {31'b0, e_ready});
    @(posedge clk);
    if (fl) begin
      e_valid = 1'b0;
      e_instr = NOP;
      e_taken = 1'b1;
      e_redir = fpc;
      m_q.delete();
      m_pc   = fpc;
      m_skip = fpc[1];
      m_drop = DROP_WORDS;
    end else begin
      if (st) begin
        e_taken = 1'b0;
      end else if (iss) begin
        ins = rvc ? {16'h0000, m_q[0]} : {m_q[1], m_q[0]};
        predict(ins, rvc, pt, off);
        tgt     = m_pc + 32'(off);
        e_instr = ins;
        e_pc    = m_pc;
        e_valid = 1'b1;
        e_comp  = rvc;
        e_taken = pt;
        if (pt) e_redir = tgt;
        for (int i = 0; i < cons; i++) void'(m_q.pop_front());
        m_pc = m_pc + (rvc ? 32'd2 : 32'd4);
      end else begin
        e_valid = 1'b0;
        e_instr = NOP;
        e_taken = 1'b0;
      end
      if (acc) begin
        if (m_drop > 0) begin
          m_drop--;
        end else if (m_skip) begin
          m_q.push_back(w[31:16]);
          m_skip = 1'b0;
        end else begin
          m_q.push_back(w[15:0]);
          m_q.push_back(w[31:16]);
        end
      end
      if (iss && pt) begin
        m_q.delete();
        m_pc   = tgt;
        m_skip = tgt[1];
        m_drop = acc ? DROP_WORDS - 1 : DROP_WORDS;
      end
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [15:0] rand_rvc();
    logic [31:0] r;
    logic [2:0]  f3;
    r = $urandom;
    case (r[18:16] % 5)
      0:       f3 = 3'b101;
      1:       f3 = 3'b001;
      2:       f3 = 3'b110;
      3:       f3 = 3'b111;
      default: f3 = 3'b000;
    endcase
    return {f3, r[12:0]} & 16'hFFFD | 16'h0001;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 6)
      0:       return r;
      1:       return {r[31:7], 7'b1101111};
      2:       return {r[31:7], 7'b1100011};
      3:       return {rand_rvc(), rand_rvc()};
      4:       return {rand_rvc(), r[15:0]};
      default: return {r[31:20], 20'h00093};
    endcase
  endfunction

  initial begin
    // Reset state.
    do_reset();
    check("rst_instr", instr_o, NOP);
    check("rst_pc", instr_pc_o, 32'h0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    check("rst_compress", {31'b0, is_compress_o}, 32'h0);
    check("rst_taken", {31'b0, taken_o}, 32'h0);
    check("rst_redirect", redirect_pc_o, 32'h0);

    // Two aligned 32-bit instructions.
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'h0010_0093);
    check("seq_pc0", instr_pc_o, 32'h8000_0000);
    step(1'b0, 32'h0);
    check("seq_pc1", instr_pc_o, 32'h8000_0004);
    check("seq_instr1", instr_o, 32'h0010_0093);
    step(1'b0, 32'h0);

    // c.nop followed by a 32-bit instruction straddling the word boundary.
    do_reset();
    step(1'b1, 32'h0093_0001);
    step(1'b0, 32'h0);
    check("rvc_compress", {31'b0, is_compress_o}, 32'h1);
    step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0010);
    step(1'b0, 32'h0);
    check("straddle_pc", instr_pc_o, 32'h8000_0002);
    check("straddle_instr", instr_o, 32'h0010_0093);
    step(1'b0, 32'h0);

    // JAL: redirect pulse, two dropped words, restart at the target.
    do_reset();
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'h0100_006F);
    step(1'b1, 32'h0000_006F);
    check("jal_target", redirect_pc_o, 32'h8000_0014);
    step(1'b1, 32'h0000_006F);
    step(1'b1, 32'h0010_0093);
    step(1'b0, 32'h0);
    check("jal_restart_pc", instr_pc_o, 32'h8000_0014);
    step(1'b0, 32'h0);

    // Backward branch taken, forward branch not taken.
    do_reset();
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'hFE00_0CE3);
    step(1'b0, 32'h0);
    check("bwd_target", redirect_pc_o, 32'h8000_0000);
    do_reset();
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'h7E00_0CE3);
    step(1'b0, 32'h0);
    check("fwd_not_taken", {31'b0, taken_o}, 32'h0);

    // Flush during stall, then skip of the lower halfword.
    do_reset();
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'h0000_0013, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0102);
    step(1'b1, 32'h0000_006F);
    step(1'b1, 32'h0000_006F);
    step(1'b1, 32'h0001_0013);
    step(1'b0, 32'h0);
    check("flush_restart_pc", instr_pc_o, 32'h8000_0102);
    step(1'b0, 32'h0);

    // Stall while the redirect pulse is high; buffer fills, ready drops.
    do_reset();
    step(1'b1, 32'h0000_0013);
    step(1'b1, 32'h0100_006F);
    step(1'b1, 32'h0000_006F);
    step(1'b1, 32'h0000_006F, 1'b1);
    step(1'b1, 32'h0000_0013, 1'b1);
    step(1'b1, 32'h0000_0013, 1'b1);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 5) != 0, rand_word(), ($urandom % 4) == 0,
           ($urandom % 40) == 0, RESET_PC + 32'(($urandom % 256) * 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
